// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped, write-back data cache with one-word lines.
// Each CPU access goes through a one-cycle tag lookup. On a miss, a dirty
// victim is written back first, the line is refilled from memory, and the
// access is replayed.
module cache_controller #(
    parameter int XLEN    = 32,
    parameter int INDEX_W = 11,
    parameter int TAG_W   = 19,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic             cpu_is_byte,
    input  logic [XLEN-1:0]  cpu_addr,
    input  logic [XLEN-1:0]  cpu_wdata,
    output logic             cpu_busy,
    output logic             cpu_done,
    output logic [XLEN-1:0]  cpu_rdata,
    output logic [XLEN-1:0]  cache_addr,
    output logic             cache_we,
    output logic             cache_is_byte,
    output logic [XLEN-1:0]  cache_wdata,
    input  logic [XLEN-1:0]  cache_rdata,
    input  logic             cache_hit,
    input  logic             cache_dirty,
    input  logic [XLEN-1:0]  cache_miss_addr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    // Byte offset inside a word (2 for a 32-bit word).
    localparam int OFFSET_W = XLEN - TAG_W - INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FETCH,
        S_REFILL
    } state_t;

    state_t           state_q, state_d;
    logic             req_we_q, req_byte_q;
    logic [XLEN-1:0]  req_addr_q, req_wdata_q, fill_q;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             mem_req_q, mem_req_d;
    logic             replay_q, replay_d;
    logic             accept, mem_take;
    logic             hit_inc, miss_inc, wb_inc;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic [7:0]       lane_byte;
    logic [XLEN-1:0]  load_word;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // A memory response only counts while we are actually requesting.
    assign mem_take  = mem_req_q & mem_ready;
    // The cache always returns the whole word. Byte loads select the lane
    // here and sign-extend it.
    assign lane_byte = cache_rdata[{req_addr_q[OFFSET_W-1:0], 3'b000} +: 8];
    assign load_word = req_byte_q ? {{(XLEN-8){lane_byte[7]}}, lane_byte} : cache_rdata;

    assign cpu_busy   = (state_q != S_IDLE);
    assign cpu_done   = done_q;
    assign cpu_rdata  = rdata_q;
    assign cache_addr = req_addr_q;
    assign mem_req    = mem_req_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign wb_cnt     = wb_cnt_q;

    // Next-state decode and per-state strobes toward the cache and memory.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        done_d        = 1'b0;
        rdata_d       = rdata_q;
        replay_d      = replay_q;
        accept        = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        wb_inc        = 1'b0;
        cache_we      = 1'b0;
        cache_is_byte = req_byte_q;
        // A byte store is replicated on all lanes. The array writes the lane
        // selected by the address.
        cache_wdata   = req_byte_q ? {(XLEN/8){req_wdata_q[7:0]}} : req_wdata_q;
        mem_we        = (state_q == S_WRITEBACK);
        mem_addr      = (state_q == S_WRITEBACK) ? cache_miss_addr
                                                 : {req_addr_q[XLEN-1:OFFSET_W], OFFSET_W'(0)};
        mem_wdata     = cache_rdata;
        case (state_q)
            S_IDLE: begin
                // The done cycle is not an acceptance cycle, so a held
                // request is taken one cycle later.
                if (cpu_req && !done_q) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cache_hit) begin
                    cache_we = req_we_q;
                    if (!req_we_q) rdata_d = load_word;
                    done_d   = 1'b1;
                    hit_inc  = !replay_q;
                    replay_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = cache_dirty ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                cache_is_byte = 1'b0;
                if (mem_take) begin
                    wb_inc  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_take) state_d = S_REFILL;
            end
            S_REFILL: begin
                cache_we      = 1'b1;
                cache_is_byte = 1'b0;
                cache_wdata   = fill_q;
                replay_d      = 1'b1;
                state_d       = S_LOOKUP;
            end
            default: state_d = S_IDLE;
        endcase
        // Drop the request for the cycle after a completion, even when
        // moving straight from writeback into fetch.
        mem_req_d = ((state_d == S_WRITEBACK) || (state_d == S_FETCH)) && !mem_take;
    end

    // Request and fill data registers. These are loaded before they are used.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers have no reset. Their contents are only read after a load, so a reset would cost logic and do nothing.
        if (accept) begin
            req_we_q    <= cpu_we;
            req_byte_q  <= cpu_is_byte;
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
        end
        if ((state_q == S_FETCH) && mem_take) fill_q <= mem_rdata;
    end

    // Control state, response registers and event counters.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values no matter the statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            mem_req_q  <= 1'b0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            mem_req_q  <= mem_req_d;
            replay_q   <= replay_d;
            hit_cnt_q  <= sat_inc(hit_cnt_q, hit_inc);
            miss_cnt_q <= sat_inc(miss_cnt_q, miss_inc);
            wb_cnt_q   <= sat_inc(wb_cnt_q, wb_inc);
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller. It contains a behavioural cache array, a
// main memory with adjustable latency, and a reference model that holds the
// architectural memory contents and which lines are resident or dirty.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_is_byte;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_busy, cpu_done;
    logic [31:0] cpu_rdata;
    logic [31:0] cache_addr, cache_wdata, cache_rdata, cache_miss_addr;
    logic        cache_we, cache_is_byte, cache_hit, cache_dirty;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_is_byte(cpu_is_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cache_addr(cache_addr), .cache_we(cache_we), .cache_is_byte(cache_is_byte),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .cache_dirty(cache_dirty), .cache_miss_addr(cache_miss_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- cache array model ----------------
    bit        c_valid [2048];
    bit        c_dirty [2048];
    bit [18:0] c_tag   [2048];
    bit [31:0] c_data  [2048];
    logic [10:0] cidx;
    logic [1:0]  clane;
    assign cidx  = cache_addr[12:2];
    assign clane = cache_addr[1:0];

    always_comb begin
        cache_hit       = c_valid[cidx] && (c_tag[cidx] == cache_addr[31:13]);
        cache_dirty     = c_valid[cidx] && c_dirty[cidx];
        cache_rdata     = c_data[cidx];
        cache_miss_addr = {c_tag[cidx], cidx, 2'b00};
    end

    // Writing a resident line updates it and marks it dirty. Writing a
    // non-resident line installs it clean, which is the refill case.
    always @(posedge clk) begin
        if (cache_we) begin
            if (c_valid[cidx] && (c_tag[cidx] == cache_addr[31:13])) begin
                if (cache_is_byte) c_data[cidx][{clane, 3'b000} +: 8] <= cache_wdata[{clane, 3'b000} +: 8];
                else               c_data[cidx] <= cache_wdata;
                c_dirty[cidx] <= 1'b1;
            end else begin
                c_valid[cidx] <= 1'b1;
                c_tag[cidx]   <= cache_addr[31:13];
                c_data[cidx]  <= cache_wdata;
                c_dirty[cidx] <= 1'b0;
            end
        end
    end

    // ---------------- main memory model ----------------
    logic [31:0] backing [logic [31:0]];
    logic [31:0] arch    [logic [31:0]];
    logic [31:0] wb_addr_log[$], wb_data_log[$], fetch_log[$];
    int mem_lat = 3;
    int wait_cnt = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] backing_rd(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : init_word(a);
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_word(a);
    endfunction

    function automatic void serve_write(input logic [31:0] a, input logic [31:0] d);
        backing[a] = d;
        wb_addr_log.push_back(a);
        wb_data_log.push_back(d);
    endfunction

    function automatic logic [31:0] serve_fetch(input logic [31:0] a);
        fetch_log.push_back(a);
        return backing_rd(a);
    endfunction

    // The response comes about mem_lat cycles after the request is seen.
    // While ready is high, the request must already have dropped.
    always @(negedge clk) begin
        if (mem_ready) check("mem_req_drop", 32'(mem_req), 32'd0);
        mem_ready <= 1'b0;
        if (rst || !mem_req || mem_ready) begin
            wait_cnt <= 0;
        end else if (wait_cnt + 1 >= mem_lat) begin
            mem_ready <= 1'b1;
            wait_cnt  <= 0;
            if (mem_we) serve_write(mem_addr, mem_wdata);
            else        mem_rdata <= serve_fetch(mem_addr);
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    bit        ref_valid [2048];
    bit        ref_dirty [2048];
    bit [18:0] ref_tag   [2048];
    int exp_hits = 0, exp_misses = 0, exp_wbs = 0;

    function automatic int sat16(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((cpu_busy || cpu_done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", 32'(cpu_busy || cpu_done), 32'd0);
    endtask

    task automatic do_access(input logic we, input logic is_byte, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit hold);
        logic [10:0] idx;
        logic [18:0] tag;
        logic [31:0] waddr, victim, old_word, exp_load, exp_wb_data, bmask;
        int lane, cycles;
        bit exp_hit, exp_wb;

        wait_idle();
        idx   = addr[12:2];
        tag   = addr[31:13];
        waddr = {addr[31:2], 2'b00};
        lane  = int'(addr[1:0]);
        exp_hit     = ref_valid[idx] && (ref_tag[idx] == tag);
        exp_wb      = !exp_hit && ref_valid[idx] && ref_dirty[idx];
        victim      = {ref_tag[idx], idx, 2'b00};
        exp_wb_data = arch_rd(victim);
        old_word    = arch_rd(waddr);
        if (is_byte) begin
            exp_load = (old_word >> (8 * lane)) & 32'hFF;
            if (exp_load[7]) exp_load = exp_load | 32'hFFFF_FF00;
        end else begin
            exp_load = old_word;
        end
        if (we) begin
            bmask = 32'hFF << (8 * lane);
            arch[waddr] = is_byte ? ((old_word & ~bmask) | ((wdata & 32'hFF) << (8 * lane))) : wdata;
        end
        if (exp_hit) exp_hits = sat16(exp_hits);
        else         exp_misses = sat16(exp_misses);
        if (exp_wb)  exp_wbs = sat16(exp_wbs);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
        ref_dirty[idx] = we || (exp_hit && ref_dirty[idx]);

        wb_addr_log.delete();
        wb_data_log.delete();
        fetch_log.delete();
        cpu_req = 1'b1; cpu_we = we; cpu_is_byte = is_byte; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        check("accept_busy", 32'(cpu_busy), 32'd1);
        if (!hold) cpu_req = 1'b0;
        cycles = 0;
        while (!cpu_done && cycles < 500) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("done_seen", 32'(cpu_done), 32'd1);
        if (hold) begin
            @(posedge clk); #1;
            check("hold_no_accept_busy", 32'(cpu_busy), 32'd0);
            check("hold_single_done", 32'(cpu_done), 32'd0);
            cpu_req = 1'b0;
        end
        if (exp_hit) check("hit_latency", 32'(cycles), 32'd1);
        if (!we) check("load_data", cpu_rdata, exp_load);
        check("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
        check("miss_cnt", 32'(miss_cnt), 32'(exp_misses));
        check("wb_cnt", 32'(wb_cnt), 32'(exp_wbs));
        check("wb_count", 32'(wb_addr_log.size()), 32'(exp_wb));
        if (exp_wb && wb_addr_log.size() == 1) begin
            check("wb_addr", wb_addr_log[0], victim);
            check("wb_data", wb_data_log[0], exp_wb_data);
        end
        check("fetch_count", 32'(fetch_log.size()), 32'(!exp_hit));
        if (!exp_hit && fetch_log.size() == 1) check("fetch_addr", fetch_log[0], waddr);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_addr;
        int g;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_is_byte = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        backing[32'h2010] = 32'hDEAD_BEEF;
        arch[32'h2010]    = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(cpu_busy), 32'd0);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_cache_we", 32'(cache_we), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("rst_wb_cnt", 32'(wb_cnt), 32'd0);
        rst = 1'b0;

        // Directed sequence.
        mem_lat = 3;
        do_access(1'b0, 1'b0, 32'h0000_2010, 32'h0, 1'b0);          // cold load
        check("cold_load_value", cpu_rdata, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b0, 32'h0000_2010, 32'h0, 1'b0);          // hit
        do_access(1'b1, 1'b0, 32'h0000_2010, 32'h1122_3344, 1'b0);  // store hit
        do_access(1'b0, 1'b0, 32'h0000_4010, 32'h0, 1'b0);          // dirty eviction
        check("evict_wb_cnt", 32'(wb_cnt), 32'd1);
        do_access(1'b1, 1'b1, 32'h0000_2012, 32'h0000_0080, 1'b0);  // byte store miss
        do_access(1'b0, 1'b1, 32'h0000_2012, 32'h0, 1'b0);          // byte load
        check("byte_sign_ext", cpu_rdata, 32'hFFFF_FF80);
        do_access(1'b1, 1'b1, 32'h0000_2013, 32'h0000_005A, 1'b0);
        do_access(1'b0, 1'b0, 32'h0000_2010, 32'h0, 1'b0);
        check("byte_merge", cpu_rdata, 32'h5A80_3344);

        // Reset while a writeback waits on memory.
        wait_idle();
        mem_lat = 20;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_is_byte = 1'b0; cpu_addr = 32'h0000_6010;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        g = 0;
        while (!(mem_req && mem_we) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("reach_writeback", 32'(mem_req && mem_we), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 32'(cpu_busy), 32'd0);
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("mid_rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("mid_rst_wb_cnt", 32'(wb_cnt), 32'd0);
        rst = 1'b0;
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
        mem_lat = 3;

        // Request held high through a dirty miss.
        do_access(1'b0, 1'b0, 32'h0000_8010, 32'h0, 1'b1);

        // Randomised accesses over a few conflicting lines.
        for (int n = 0; n < 250; n++) begin
            logic [10:0] ridx;
            logic [18:0] rtag;
            logic [1:0]  rlane;
            logic        rwe, rbyte;
            case ($urandom_range(0, 4))
                0: ridx = 11'd4;
                1: ridx = 11'd5;
                2: ridx = 11'd6;
                3: ridx = 11'd100;
                default: ridx = 11'd2047;
            endcase
            rtag  = 19'($urandom_range(1, 3));
            rwe   = 1'($urandom_range(0, 1));
            rbyte = 1'($urandom_range(0, 1));
            rlane = rbyte ? 2'($urandom_range(0, 3)) : 2'd0;
            r_addr  = {rtag, ridx, rlane};
            mem_lat = $urandom_range(1, 4);
            do_access(rwe, rbyte, r_addr, $urandom, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
